// File: rtl/y_mux_4to1.sv
// rtl/y_mux_4to1.sv - SIZE-bit 4-to-1 mux built from 2-to-1 stages, with combinational and registered outputs
module y_mux_4to1 #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] a2,
  input  logic [SIZE-1:0] a3,
  input  logic [1:0]      c,
  output logic [SIZE-1:0] z_q
);

  logic [SIZE-1:0] lo;
  logic [SIZE-1:0] hi;
  logic [SIZE-1:0] z_d;

  // Per-bit ?: keeps the standard X-merge behaviour when the select is unknown.
  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    assign lo[i] = c[0] ? a1[i] : a0[i];
    assign hi[i] = c[0] ? a3[i] : a2[i];
    assign z[i]  = c[1] ? hi[i] : lo[i];
  end

  always_comb begin
    z_d = z;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

endmodule

// File: tb/tb_y_mux_4to1.sv
// tb/tb_y_mux_4to1.sv - directed and randomized checks of y_mux_4to1 against a word-indexed reference model
module tb_y_mux_4to1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] words [4];
  logic [1:0]  c;
  logic        c_bit;

  logic [31:0] z32, zq32, zb, zqb;
  logic [7:0]  z8, zq8;
  logic [0:0]  z1, zq1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  y_mux_4to1 #(.SIZE(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .z(z32),
    .a0(words[0][31:0]), .a1(words[1][31:0]), .a2(words[2][31:0]), .a3(words[3][31:0]),
    .c(c), .z_q(zq32)
  );

  y_mux_4to1 #(.SIZE(32)) u_bitsel (
    .clk(clk), .rst_n(rst_n), .z(zb),
    .a0(words[0][31:0]), .a1(words[1][31:0]), .a2(words[2][31:0]), .a3(words[3][31:0]),
    .c({1'b0, c_bit}), .z_q(zqb)
  );

  y_mux_4to1 #(.SIZE(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .z(z8),
    .a0(words[0][7:0]), .a1(words[1][7:0]), .a2(words[2][7:0]), .a3(words[3][7:0]),
    .c(c), .z_q(zq8)
  );

  y_mux_4to1 #(.SIZE(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .z(z1),
    .a0(words[0][0:0]), .a1(words[1][0:0]), .a2(words[2][0:0]), .a3(words[3][0:0]),
    .c(c), .z_q(zq1)
  );

  // Reference: the select value is simply an index into the four input words.
  function automatic logic [63:0] model(input logic [1:0] s, input int w);
    logic [63:0] r;
    r = words[s];
    if (w < 64) r = r & ((64'd1 << w) - 64'd1);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic randomize_words();
    for (int k = 0; k < 4; k++) words[k] = {$urandom, $urandom};
  endtask

  task automatic sweep_all(input string tag);
    for (int s = 0; s < 4; s++) begin
      c = s[1:0];
      #1;
      check({tag, "_z32"}, {32'b0, z32}, model(c, 32));
      check({tag, "_z8"},  {56'b0, z8},  model(c, 8));
      check({tag, "_z1"},  {63'b0, z1},  model(c, 1));
    end
  endtask

  initial begin
    logic [63:0] saved;
    words[0] = 64'h12153524;
    words[1] = 64'hC0895E81;
    words[2] = 64'h8484D609;
    words[3] = 64'hB1F05663;
    c = 2'd2;
    c_bit = 1'b0;
    #1;
    check("reset_zq32", {32'b0, zq32}, 64'd0);
    check("reset_zq8",  {56'b0, zq8},  64'd0);
    check("reset_zq1",  {63'b0, zq1},  64'd0);
    check("reset_zqb",  {32'b0, zqb},  64'd0);
    check("reset_z_valid", {32'b0, z32}, 64'h8484D609);

    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 4; s++) begin
      c = s[1:0];
      #1;
      check("sweep_z", {32'b0, z32}, model(c, 32));
      check("sweep_lowbits", {62'b0, z32[1:0]}, {62'b0, words[s][1:0]});
    end

    words[0] = 64'hFFFF0000;
    words[1] = 64'h0000FFFF;
    words[2] = 64'hAAAAAAAA;
    words[3] = 64'h55555555;
    c = 2'd1;
    #1 check("bitind_c1", {32'b0, z32}, 64'h0000FFFF);
    c = 2'd2;
    #1 check("bitind_c2", {32'b0, z32}, 64'hAAAAAAAA);

    for (int n = 0; n < 4; n++) begin
      randomize_words();
      sweep_all("param");
    end

    for (int n = 0; n < 10; n++) begin
      randomize_words();
      c_bit = 1'($urandom);
      #1 check("bitsel_z", {32'b0, zb}, model({1'b0, c_bit}, 32));
    end

    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      randomize_words();
      c = 2'($urandom);
      #1 check("rand_z", {32'b0, z32}, model(c, 32));
      @(posedge clk);
      #1 check("rand_zq", {32'b0, zq32}, model(c, 32));
      saved = model(c, 32);
      randomize_words();
      #1 check("hold_zq", {32'b0, zq32}, saved);
      check("hold_z", {32'b0, z32}, model(c, 32));
    end

    @(posedge clk);
    #1;
    randomize_words();
    c = 2'd0;
    @(posedge clk);
    #1 check("lat_zq_before", {32'b0, zq32}, model(2'd0, 32));
    c = 2'd3;
    #1 check("lat_z_now", {32'b0, z32}, model(2'd3, 32));
    check("lat_zq_held", {32'b0, zq32}, model(2'd0, 32));
    @(posedge clk);
    #1 check("lat_zq_after", {32'b0, zq32}, model(2'd3, 32));

    words[0] = 64'hDEADBEEF;
    c = 2'd0;
    @(posedge clk);
    #1 check("arst_capture", {32'b0, zq32}, 64'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1 check("arst_zq_clear", {32'b0, zq32}, 64'd0);
    check("arst_z_live", {32'b0, z32}, 64'hDEADBEEF);
    @(posedge clk);
    #1 check("arst_edge_held", {32'b0, zq32}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst_release_wait", {32'b0, zq32}, 64'd0);
    @(posedge clk);
    #1 check("arst_first_capture", {32'b0, zq32}, 64'hDEADBEEF);

    randomize_words();
    words[3] = 'x;
    c = 2'd0;
    #1 check("xin_z", {32'b0, z32}, model(2'd0, 32));
    check("xin_noX", {63'b0, $isunknown(z32)}, 64'd0);

    for (int k = 0; k < 4; k++) words[k] = 64'h5A5A_C3C3;
    c = 2'bxx;
    #1 check("xsel_agree", {32'b0, z32}, 64'h5A5AC3C3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
